// File: rtl/regarb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Contents: address/data widths, the write-request record carried through the
// multiply/divide result FIFO, and the write-port grant encoding.
package regarb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Signal bundle between the arbiter and its neighbours (WB stage, MDU, decode,
// register file). The modport named master is the environment side and the
// modport named slave is the arbiter side.
//   wb_*       pipeline writeback (no back-pressure)
//   md_*       multiply/divide result handshake and issue notification
//   id_*       decode-stage register indices; hazard_stall / hold_req back
//   rf_*       register-file write port
interface regfile_write_arbiter_if;
  import regarb_pkg::*;

  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;
  logic                  md_valid;
  logic                  md_ready;
  logic [REG_ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0]     md_data;
  logic                  md_issue;
  logic [REG_ADDR_W-1:0] md_issue_rd;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  hazard_stall;
  logic                  hold_req;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;

  modport master (
    output wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, md_issue, md_issue_rd,
    output id_rs, id_rt, id_rd,
    input  md_ready, hazard_stall, hold_req, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, md_issue, md_issue_rd,
    input  id_rs, id_rt, id_rd,
    output md_ready, hazard_stall, hold_req, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regarb_fifo.sv
// Synchronous FIFO of write requests buffering multiply/divide results.
// Ports: clk, rst (sync, active-high); i_push/i_data enqueue; i_pop dequeue;
// o_head is the oldest entry; o_full / o_empty derive from registered pointers.
// Callers must not push when full or pop when empty.
module regarb_fifo
  import regarb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  wr_req_t i_data,
  input  logic    i_pop,
  output wr_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  wr_req_t         r_mem [FIFO_DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PtrW:0]   r_wptr;
  logic [PtrW:0]   r_rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (PtrW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[PtrW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rptr[PtrW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                   (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between pipeline writeback and the
// multiply/divide unit. WB always wins; buffered MDU results drain when WB is idle.
// A busy scoreboard over r1..r31 drives the decode hazard stall.
// Ports: clk, rst (sync, active-high); bus (regfile_write_arbiter_if.slave).
// Optional macro REGARB_STARVE_GUARD_EN: when defined, a saturating counter of
// cycles in which a buffered result is blocked by WB raises hold_req at
// STARVE_LIMIT; when undefined, hold_req is tied low.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1)
  begin : g_param_check
    $error("regfile_write_arbiter: bad FIFO_DEPTH or STARVE_LIMIT");
  end

  wr_req_t     w_head;
  wr_req_t     w_push_data;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_grant_md;
  gnt_e        w_gnt;
  logic [31:0] r_busy;
  logic [31:0] w_busy_d;

  assign w_push_data = '{rd: bus.md_rd, data: bus.md_data};
  assign w_push      = bus.md_valid & ~w_full;
  assign bus.md_ready = ~w_full;

  regarb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_grant_md),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Grant and write-port mux; outputs forced quiet during reset.
  always_comb begin
    w_gnt        = GNT_NONE;
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (!rst) begin
      if (bus.wb_we)     w_gnt = GNT_WB;
      else if (!w_empty) w_gnt = GNT_MD;
    end
    unique case (w_gnt)
      GNT_WB: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_rd;
        bus.rf_wdata = bus.wb_data;
      end
      GNT_MD: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = w_head.rd;
        bus.rf_wdata = w_head.data;
      end
      default: ;
    endcase
  end

  assign w_grant_md = (w_gnt == GNT_MD);

  // Clear before set so a same-register issue in the draining cycle wins.
  always_comb begin
    w_busy_d = r_busy;
    if (w_grant_md) w_busy_d[w_head.rd] = 1'b0;
    if (bus.md_issue && bus.md_issue_rd != '0) w_busy_d[bus.md_issue_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_d;
  end

  assign bus.hazard_stall = r_busy[bus.id_rs] | r_busy[bus.id_rt] | r_busy[bus.id_rd];

`ifdef REGARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] r_starve;

  always_ff @(posedge clk) begin
    if (rst || w_empty || w_grant_md) begin
      r_starve <= '0;
    end else if (bus.wb_we && r_starve != CntW'(STARVE_LIMIT)) begin
      r_starve <= r_starve + CntW'(1);
    end
  end

  assign bus.hold_req = (r_starve == CntW'(STARVE_LIMIT));
`else
  assign bus.hold_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Expected register-file writes are
// queued when the stimulus that causes them is driven and popped as the write
// port fires. Inputs change 1 ns after posedge; outputs are sampled at negedge.
module tb_regfile_write_arbiter;
  import regarb_pkg::*;

`ifdef REGARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_req_t q_wb[$];
  wr_req_t q_md[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_we   = we;
    bus.wb_rd   = rd;
    bus.wb_data = data;
    if (we) q_wb.push_back('{rd: rd, data: data});
  endtask

  // exp_acc: the bench expects this beat to be accepted at the coming edge.
  task automatic md(input logic v, input logic [4:0] rd, input logic [31:0] data,
                    input bit exp_acc);
    bus.md_valid = v;
    bus.md_rd    = rd;
    bus.md_data  = data;
    if (v && exp_acc) q_md.push_back('{rd: rd, data: data});
  endtask

  task automatic settle();
    wr_req_t e;
    @(negedge clk);
    if (bus.rf_we === 1'b1) begin
      if (bus.wb_we) begin
        if (q_wb.size() == 0) chk("wb_unexpected_write", 32'd1, 32'd0);
        else begin
          e = q_wb.pop_front();
          chk("wb_waddr", 32'(bus.rf_waddr), 32'(e.rd));
          chk("wb_wdata", bus.rf_wdata, e.data);
        end
      end else begin
        if (q_md.size() == 0) chk("md_unexpected_write", 32'd1, 32'd0);
        else begin
          e = q_md.pop_front();
          chk("md_waddr", 32'(bus.rf_waddr), 32'(e.rd));
          chk("md_wdata", bus.rf_wdata, e.data);
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;
    bus.md_issue = 0; bus.md_issue_rd = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;

    // Write port quiet while in reset even with WB active.
    bus.wb_we = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD;
    settle();
    chk("rst_rf_we", 32'(bus.rf_we), 0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr), 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    adv();
    bus.wb_we = 0;
    adv();
    rst = 0;

    // Idle after reset.
    settle();
    chk("idle_rf_we", 32'(bus.rf_we), 0);
    chk("idle_md_ready", 32'(bus.md_ready), 1);
    chk("idle_hazard", 32'(bus.hazard_stall), 0);
    chk("idle_hold", 32'(bus.hold_req), 0);
    adv();

    // Plain WB write, same cycle.
    wb(1, 5'd5, 32'h1234);
    settle();
    chk("wb_rf_we", 32'(bus.rf_we), 1);
    adv();
    wb(0, 0, 0);

    // Issue to r9: stall from the next cycle until two edges after acceptance.
    bus.md_issue = 1; bus.md_issue_rd = 5'd9; bus.id_rs = 5'd9;
    settle();
    chk("issue_same_cycle_no_stall", 32'(bus.hazard_stall), 0);
    adv();
    bus.md_issue = 0;
    settle();
    chk("issue_stall", 32'(bus.hazard_stall), 1);
    adv();
    md(1, 5'd9, 32'hCAFE, 1);
    settle();
    chk("r9_ready", 32'(bus.md_ready), 1);
    chk("r9_stall_accept", 32'(bus.hazard_stall), 1);
    adv();
    md(0, 0, 0, 0);
    settle();
    chk("r9_write_cycle_we", 32'(bus.rf_we), 1);
    chk("r9_stall_write_cycle", 32'(bus.hazard_stall), 1);
    adv();
    settle();
    chk("r9_stall_cleared", 32'(bus.hazard_stall), 0);
    adv();
    bus.id_rs = 0;

    // Fill the FIFO behind WB traffic, third result back-pressured.
    wb(1, 5'd1, 32'h11); md(1, 5'd3, 32'hA, 1);
    settle(); chk("fill_ready0", 32'(bus.md_ready), 1); adv();
    wb(1, 5'd2, 32'h22); md(1, 5'd4, 32'hB, 1);
    settle(); chk("fill_ready1", 32'(bus.md_ready), 1); adv();
    wb(1, 5'd2, 32'h33); md(1, 5'd5, 32'hC, 0);
    settle(); chk("full_ready", 32'(bus.md_ready), 0); adv();
    wb(0, 0, 0);
    settle(); chk("drain_ready_still_full", 32'(bus.md_ready), 0); adv();
    md(1, 5'd5, 32'hC, 1);
    settle(); chk("drain_ready_again", 32'(bus.md_ready), 1); adv();
    md(0, 0, 0, 0);
    settle(); adv();

    // Starvation: buffered r7 blocked by continuous WB.
    wb(1, 5'd10, 32'h100); md(1, 5'd7, 32'h77, 1);
    settle(); adv();
    md(0, 0, 0, 0);
    for (int i = 0; i < LIMIT + 2; i++) begin
      wb(1, 5'd10, 32'(i));
      settle();
      chk($sformatf("starve_hold_%0d", i), 32'(bus.hold_req),
          (GUARD && i >= LIMIT) ? 32'd1 : 32'd0);
      adv();
    end
    wb(0, 0, 0);
    settle();
    chk("starve_grant_we", 32'(bus.rf_we), 1);
    chk("starve_hold_grant", 32'(bus.hold_req), GUARD ? 32'd1 : 32'd0);
    adv();
    settle();
    chk("starve_hold_after", 32'(bus.hold_req), 0);
    adv();

    // Same-cycle set and clear of r6: set wins.
    bus.md_issue = 1; bus.md_issue_rd = 5'd6;
    settle(); adv();
    bus.md_issue = 0;
    md(1, 5'd6, 32'h66, 1);
    settle(); adv();
    md(0, 0, 0, 0);
    bus.md_issue = 1; bus.md_issue_rd = 5'd6;
    settle(); adv();
    bus.md_issue = 0; bus.id_rs = 5'd6;
    settle(); chk("r6_set_wins_rs", 32'(bus.hazard_stall), 1); adv();
    bus.id_rs = 0; bus.id_rt = 5'd6;
    settle(); chk("r6_rt", 32'(bus.hazard_stall), 1); adv();
    bus.id_rt = 0; bus.id_rd = 5'd6;
    settle(); chk("r6_rd", 32'(bus.hazard_stall), 1); adv();
    bus.id_rd = 0;
    bus.md_issue = 1; bus.md_issue_rd = 5'd0;
    settle(); adv();
    bus.md_issue = 0;
    settle(); chk("r0_never_busy", 32'(bus.hazard_stall), 0); adv();
    md(1, 5'd6, 32'h67, 1);
    settle(); adv();
    md(0, 0, 0, 0);
    settle(); adv();
    bus.id_rs = 5'd6;
    settle(); chk("r6_cleared", 32'(bus.hazard_stall), 0); adv();

    // Reset mid-operation discards a buffered result and busy bits.
    wb(1, 5'd11, 32'h5); md(1, 5'd13, 32'hD, 0);
    bus.md_issue = 1; bus.md_issue_rd = 5'd12;
    settle(); adv();
    md(0, 0, 0, 0); bus.md_issue = 0; bus.wb_we = 0;
    rst = 1;
    settle(); chk("midrst_rf_we", 32'(bus.rf_we), 0); adv();
    rst = 0; bus.id_rs = 5'd12;
    settle();
    chk("midrst_stall", 32'(bus.hazard_stall), 0);
    chk("midrst_ready", 32'(bus.md_ready), 1);
    chk("midrst_rf_we_after", 32'(bus.rf_we), 0);
    adv();
    settle(); adv();

    chk("wb_queue_drained", 32'(q_wb.size()), 0);
    chk("md_queue_drained", 32'(q_md.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
